// File: rtl/axi4_burst_slave.sv
// AXI4 memory-mapped burst slave: FIXED/INCR bursts, byte strobes, ID echo, dual-ported word memory.
// WRAP bursts are compiled in only when AXI4_BURST_SLV_WRAP_EN is defined; otherwise they return SLVERR.
module axi4_burst_slave #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned MEMORY_DEPTH = 1024,
    parameter int unsigned ID_WIDTH     = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned OFFS_W = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(MEMORY_DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
`ifdef AXI4_BURST_SLV_WRAP_EN
    localparam logic [1:0] BURST_WRAP  = 2'b10;
`endif

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

    // Whole-burst legality, judged once from the address-phase fields.
    function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] a;
        logic [31:0] s;
        logic [31:0] last;
        logic        err;
        a    = 32'(addr);
        s    = 32'd1 << size;
        last = a;
        err  = (32'(size) > OFFS_W);
        case (burst)
            BURST_FIXED: last = a;
            BURST_INCR: begin
                last = a + 32'(len) * s;
                err  = err || (last[31:12] != a[31:12]);
            end
`ifdef AXI4_BURST_SLV_WRAP_EN
            BURST_WRAP: begin
                err  = err || !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)
                           || ((a & (s - 32'd1)) != 32'd0);
                last = (a & ~((32'(len) + 32'd1) * s - 32'd1)) + 32'(len) * s;
            end
`endif
            default: err = 1'b1;
        endcase
        return err || ((last >> OFFS_W) >= 32'(MEMORY_DEPTH));
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                       input logic [7:0] len, input logic [2:0] size,
                                                       input logic [1:0] burst);
        logic [31:0] a;
        logic [31:0] s;
        logic [31:0] nxt;
        a   = 32'(addr);
        s   = 32'd1 << size;
        nxt = a;
        if (burst == BURST_INCR) begin
            nxt = a + s;
        end
`ifdef AXI4_BURST_SLV_WRAP_EN
        else if (burst == BURST_WRAP) begin
            nxt = (a & ~((32'(len) + 32'd1) * s - 32'd1)) | ((a + s) & ((32'(len) + 32'd1) * s - 32'd1));
        end
`endif
        return ADDR_WIDTH'(nxt);
    endfunction

    w_state_t              w_state;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len;
    logic [7:0]            w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic [ID_WIDTH-1:0]   w_id;
    logic                  w_err;
    logic                  w_beat;
    logic                  w_end;
    logic                  w_mismatch;
    logic                  mem_we;
    logic [IDX_W-1:0]      w_idx;

    assign w_beat     = (w_state == W_DATA) && WVALID && WREADY;
    assign w_end      = WLAST || (w_cnt == w_len);
    assign w_mismatch = WLAST != (w_cnt == w_len);
    assign mem_we     = w_beat && !w_err;
    assign w_idx      = IDX_W'(w_addr >> OFFS_W);

    // Write channel FSM.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state <= W_IDLE;
            AWREADY <= 1'b1;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BRESP   <= RESP_OKAY;
            BID     <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_id    <= '0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (AWVALID && AWREADY) begin
                    w_addr  <= AWADDR;
                    w_len   <= AWLEN;
                    w_size  <= AWSIZE;
                    w_burst <= AWBURST;
                    w_id    <= AWID;
                    w_err   <= burst_err(AWADDR, AWLEN, AWSIZE, AWBURST);
                    w_cnt   <= '0;
                    AWREADY <= 1'b0;
                    w_state <= W_ADDR;
                end
                W_ADDR: begin
                    WREADY  <= 1'b1;
                    w_state <= W_DATA;
                end
                W_DATA: if (w_beat) begin
                    w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
                    w_cnt  <= w_cnt + 8'd1;
                    if (w_end) begin
                        WREADY  <= 1'b0;
                        BVALID  <= 1'b1;
                        BID     <= w_id;
                        BRESP   <= (w_err || w_mismatch) ? RESP_SLVERR : RESP_OKAY;
                        w_state <= W_RESP;
                    end
                end
                W_RESP: if (BREADY) begin
                    BVALID  <= 1'b0;
                    AWREADY <= 1'b1;
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Memory write port; contents survive reset.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (WSTRB[b]) mem[w_idx][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    r_state_t              r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [7:0]            r_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_err;
    logic [IDX_W-1:0]      r_idx;

    assign r_idx = IDX_W'(r_addr >> OFFS_W);

    // Read channel FSM; RVALID low for one cycle between beats while the next word is fetched.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b1;
            RVALID  <= 1'b0;
            RLAST   <= 1'b0;
            RRESP   <= RESP_OKAY;
            RDATA   <= '0;
            RID     <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: if (ARVALID && ARREADY) begin
                    r_addr  <= ARADDR;
                    r_len   <= ARLEN;
                    r_size  <= ARSIZE;
                    r_burst <= ARBURST;
                    r_err   <= burst_err(ARADDR, ARLEN, ARSIZE, ARBURST);
                    RID     <= ARID;
                    r_cnt   <= '0;
                    ARREADY <= 1'b0;
                    r_state <= R_ADDR;
                end
                R_ADDR: r_state <= R_DATA;
                R_DATA: begin
                    if (!RVALID) begin
                        RVALID <= 1'b1;
                        RDATA  <= r_err ? '0 : mem[r_idx];
                        RRESP  <= r_err ? RESP_SLVERR : RESP_OKAY;
                        RLAST  <= (r_cnt == r_len);
                    end else if (RREADY) begin
                        RVALID <= 1'b0;
                        if (RLAST) begin
                            RLAST   <= 1'b0;
                            ARREADY <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_cnt  <= r_cnt + 8'd1;
                            r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_burst_slave.sv
// Directed bench for axi4_burst_slave: bursts, strobes, wrap, error bursts, early WLAST, mid-burst reset.
`timescale 1ns/1ps
module tb_axi4_burst_slave;
    localparam int LIMIT = 64;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [3:0]  AWID;
    logic [15:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [3:0]  ARID;
    logic [15:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    axi4_burst_slave dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic [15:0] rd_last;
    logic [3:0]  rd_id;
    int          rd_lat;
    int          rd_gap;
    logic [1:0]  wr_resp;
    logic [3:0]  wr_bid;
    int          wr_lat;
    logic        aw_after_b;
    logic [31:0] exp_wrap [4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return AWREADY;
            1:       return WREADY;
            2:       return BVALID;
            3:       return ARREADY;
            default: return RVALID;
        endcase
    endfunction

    // Waits (bounded) until the selected ready/valid is high; n = edges waited.
    task automatic wait_hi(input int which, input string tag, output int n);
        n = 0;
        while (!sig(which) && n < LIMIT) begin
            tick();
            n++;
        end
        if (n >= LIMIT) check({tag, "_timeout"}, 64'(sig(which)), 64'd1);
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int nbeats, input logic [31:0] d0,
                             input logic [3:0] strb);
        int n;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWBURST = burst; AWVALID = 1'b1;
        wait_hi(0, "awready", n);
        tick();
        AWVALID = 1'b0;
        wait_hi(1, "wready", n);
        wr_lat = n;
        for (int i = 0; i < nbeats; i++) begin
            WVALID = 1'b1; WDATA = d0 + 32'(i); WSTRB = strb; WLAST = (i == nbeats - 1);
            wait_hi(1, "wready", n);
            tick();
        end
        WVALID = 1'b0; WLAST = 1'b0;
        BREADY = 1'b1;
        wait_hi(2, "bvalid", n);
        wr_resp = BRESP; wr_bid = BID;
        tick();
        BREADY = 1'b0;
        aw_after_b = AWREADY;
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int n;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        wait_hi(3, "arready", n);
        tick();
        ARVALID = 1'b0;
        RREADY = 1'b1;
        rd_last = '0;
        for (int i = 0; i <= int'(len); i++) begin
            wait_hi(4, "rvalid", n);
            if (i == 0) rd_lat = n;
            if (i == 1) rd_gap = n;
            rd_data[i] = RDATA; rd_resp[i] = RRESP; rd_last[i] = RLAST; rd_id = RID;
            tick();
        end
        RREADY = 1'b0;
    endtask

    initial begin
        int n;
        ARESETn = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
        tick();
        tick();
        check("rst_awready", 64'(AWREADY), 64'd1);
        check("rst_arready", 64'(ARREADY), 64'd1);
        check("rst_valids", 64'({WREADY, BVALID, RVALID, RLAST}), 64'd0);
        check("rst_resps", 64'({BRESP, RRESP}), 64'd0);
        check("rst_rdata", 64'(RDATA), 64'd0);
        check("rst_ids", 64'({BID, RID}), 64'd0);
        ARESETn = 1'b1;
        tick();

        // INCR write then read back
        axi_write(4'd5, 16'h0010, 8'd3, 2'b01, 4, 32'hA0, 4'hF);
        check("incr_bresp", 64'(wr_resp), 64'd0);
        check("incr_bid", 64'(wr_bid), 64'd5);
        check("incr_wready_lat", 64'(wr_lat), 64'd1);
        axi_read(4'd9, 16'h0010, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) check($sformatf("incr_rdata%0d", i), 64'(rd_data[i]), 64'(32'hA0 + 32'(i)));
        check("incr_rlast", 64'(rd_last), 64'h8);
        check("incr_rresp", 64'({rd_resp[0], rd_resp[1], rd_resp[2], rd_resp[3]}), 64'd0);
        check("incr_rid", 64'(rd_id), 64'd9);
        check("incr_rvalid_lat", 64'(rd_lat), 64'd2);
        check("incr_beat_gap", 64'(rd_gap), 64'd1);

        // Byte strobes
        axi_write(4'd1, 16'h0000, 8'd0, 2'b01, 1, 32'hFFFF_FFFF, 4'hF);
        axi_write(4'd2, 16'h0000, 8'd0, 2'b01, 1, 32'h1234_5678, 4'b0101);
        check("strb_bresp", 64'(wr_resp), 64'd0);
        axi_read(4'd3, 16'h0000, 8'd0, 3'd2, 2'b01);
        check("strb_rdata", 64'(rd_data[0]), 64'hFF34_FF78);

        // FIXED burst: every beat hits the same word
        axi_write(4'd4, 16'h0040, 8'd2, 2'b00, 3, 32'hD0, 4'hF);
        check("fixed_bresp", 64'(wr_resp), 64'd0);
        axi_read(4'd4, 16'h0040, 8'd1, 3'd2, 2'b00);
        check("fixed_rdata0", 64'(rd_data[0]), 64'hD2);
        check("fixed_rdata1", 64'(rd_data[1]), 64'hD2);

        // WRAP burst over a prefilled 16-byte container
        axi_write(4'd6, 16'h0030, 8'd3, 2'b01, 4, 32'hC0, 4'hF);
        axi_write(4'd7, 16'h0038, 8'd3, 2'b10, 4, 32'hB0, 4'hF);
`ifdef AXI4_BURST_SLV_WRAP_EN
        check("wrap_bresp", 64'(wr_resp), 64'd0);
        exp_wrap[0] = 32'hB2; exp_wrap[1] = 32'hB3; exp_wrap[2] = 32'hB0; exp_wrap[3] = 32'hB1;
`else
        check("wrap_bresp", 64'(wr_resp), 64'd2);
        exp_wrap[0] = 32'hC0; exp_wrap[1] = 32'hC1; exp_wrap[2] = 32'hC2; exp_wrap[3] = 32'hC3;
`endif
        axi_read(4'd8, 16'h0030, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) check($sformatf("wrap_rdata%0d", i), 64'(rd_data[i]), 64'(exp_wrap[i]));

        // 4 KB crossing read
        axi_read(4'd1, 16'h0FFC, 8'd1, 3'd2, 2'b01);
        check("xing_rresp", 64'({rd_resp[0], rd_resp[1]}), 64'hA);
        check("xing_rdata", 64'({rd_data[0], rd_data[1]}), 64'd0);
        check("xing_rlast", 64'(rd_last), 64'h2);

        // Oversize and reserved-burst reads
        axi_read(4'd2, 16'h0010, 8'd0, 3'd3, 2'b01);
        check("size_rresp", 64'(rd_resp[0]), 64'd2);
        check("size_rdata", 64'(rd_data[0]), 64'd0);
        axi_read(4'd3, 16'h0010, 8'd1, 3'd2, 2'b11);
        check("rsvd_rresp", 64'({rd_resp[0], rd_resp[1]}), 64'hA);
        check("rsvd_rlast", 64'(rd_last), 64'h2);

        // Erroring write leaves memory alone
        axi_write(4'd3, 16'h0FFC, 8'd0, 2'b01, 1, 32'h55, 4'hF);
        axi_write(4'd4, 16'h0FFC, 8'd1, 2'b01, 2, 32'h77, 4'hF);
        check("errw_bresp", 64'(wr_resp), 64'd2);
        axi_read(4'd5, 16'h0FFC, 8'd0, 3'd2, 2'b01);
        check("errw_mem", 64'(rd_data[0]), 64'h55);

        // Early WLAST
        axi_write(4'hA, 16'h0080, 8'd3, 2'b01, 2, 32'hE0, 4'hF);
        check("early_bresp", 64'(wr_resp), 64'd2);
        check("early_bid", 64'(wr_bid), 64'hA);
        check("early_awready", 64'(aw_after_b), 64'd1);
        axi_read(4'd6, 16'h0080, 8'd1, 3'd2, 2'b01);
        check("early_rdata0", 64'(rd_data[0]), 64'hE0);
        check("early_rdata1", 64'(rd_data[1]), 64'hE1);

        // Reset while beat 2 of a read is on the bus
        ARID = 4'hC; ARADDR = 16'h0010; ARLEN = 8'd3; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
        wait_hi(3, "arready", n);
        tick();
        ARVALID = 1'b0;
        RREADY = 1'b1;
        wait_hi(4, "rvalid", n);
        tick();
        wait_hi(4, "rvalid", n);
        ARESETn = 1'b0;
        #1;
        check("mrst_rvalid", 64'(RVALID), 64'd0);
        check("mrst_ready", 64'({ARREADY, AWREADY}), 64'h3);
        RREADY = 1'b0;
        tick();
        tick();
        ARESETn = 1'b1;
        tick();
        axi_read(4'hD, 16'h0010, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) check($sformatf("mrst_rdata%0d", i), 64'(rd_data[i]), 64'(32'hA0 + 32'(i)));
        check("mrst_rid", 64'(rd_id), 64'hD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
